// File: rtl/serial_add_ctrl_if.sv
// Host-side bundle for the bit-serial adder controller.
// start/a/b/cin request an add; busy/done/sum/cout report it.
interface serial_add_ctrl_if #(
  parameter int N = 8
);
  logic         start;
  logic [N-1:0] a;
  logic [N-1:0] b;
  logic         cin;
  logic         busy;
  logic         done;
  logic [N-1:0] sum;
  logic         cout;

  modport master (
    output start, a, b, cin,
    input  busy, done, sum, cout
  );

  modport slave (
    input  start, a, b, cin,
    output busy, done, sum, cout
  );
endinterface

// File: rtl/serial_add_ctrl.sv
// Bit-serial adder: one fa_1 cell sequenced LSB-first over N cycles.
// Ports: clk, rst (sync, active-high), bus (slave: start/a/b/cin in; busy/done/sum/cout out).
module fa_1 (
  input  logic x,
  input  logic y,
  input  logic rin,
  output logic s,
  output logic r
);
  assign s = x ^ y ^ rin;
  assign r = (x & y) | (x & rin) | (y & rin);
endmodule

module serial_add_ctrl #(
  parameter int N = 8
) (
  input logic              clk,
  input logic              rst,
  serial_add_ctrl_if.slave bus
);
  localparam int CW = $clog2(N) + 1;
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t        state_q, state_d;
  logic [N-1:0]  opa_q, opa_d;
  logic [N-1:0]  opb_q, opb_d;
  logic [N-1:0]  sum_q, sum_d;
  logic          carry_q, carry_d;
  logic          cout_q, cout_d;
  logic [CW-1:0] cnt_q, cnt_d;

  logic          s, r;
  logic [N:0]    sum_sh;

  fa_1 u_fa (
    .x   (opa_q[0]),
    .y   (opb_q[0]),
    .rin (carry_q),
    .s   (s),
    .r   (r)
  );

  // Result bit enters at the MSB; after N shifts it is LSB-aligned.
  assign sum_sh = {s, sum_q};

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      opa_q   <= '0;
      opb_q   <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      opa_q   <= opa_d;
      opb_q   <= opb_d;
      sum_q   <= sum_d;
      carry_q <= carry_d;
      cout_q  <= cout_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    opa_d   = opa_q;
    opb_d   = opb_q;
    sum_d   = sum_q;
    carry_d = carry_q;
    cout_d  = cout_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (bus.start) begin
          opa_d   = bus.a;
          opb_d   = bus.b;
          carry_d = bus.cin;
          cnt_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        sum_d   = sum_sh[N:1];
        opa_d   = opa_q >> 1;
        opb_d   = opb_q >> 1;
        carry_d = r;
        cnt_d   = cnt_q + 1'b1;
        if (cnt_q == LAST) begin
          cout_d  = r;
          state_d = DONE;
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign bus.busy = (state_q == RUN);
  assign bus.done = (state_q == DONE);
  assign bus.sum  = sum_q;
  assign bus.cout = cout_q;
endmodule

// File: tb/tb_serial_add_ctrl.sv
// Testbench for serial_add_ctrl: directed and random adds vs a + b + cin.
// Checks latency, busy length, done pulse, ignored restart and mid-run reset.
module tb_serial_add_ctrl;
  localparam int N = 8;

  logic clk;
  logic rst;
  int   errors;
  int   checks;

  serial_add_ctrl_if #(.N(N)) bus ();

  serial_add_ctrl #(.N(N)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Full add transaction; reference result is plain arithmetic.
  task automatic run_add(input string tag, input logic [N-1:0] a,
                         input logic [N-1:0] b, input logic cin);
    logic [N:0] e;
    int k;
    int bc;
    e = {1'b0, a} + {1'b0, b} + {{N{1'b0}}, cin};
    @(negedge clk);
    bus.start = 1'b1;
    bus.a = a;
    bus.b = b;
    bus.cin = cin;
    @(negedge clk);
    bus.start = 1'b0;
    bus.a = ~a;
    bus.b = ~b;
    bus.cin = ~cin;
    k = 1;
    bc = 0;
    while (!bus.done && k < 50) begin
      if (bus.busy) bc++;
      @(negedge clk);
      k++;
    end
    chk({tag, ".lat"}, k, N + 1);
    chk({tag, ".busy"}, bc, N);
    chk({tag, ".sum"}, bus.sum, e[N-1:0]);
    chk({tag, ".cout"}, bus.cout, e[N]);
    @(negedge clk);
    chk({tag, ".pulse"}, {bus.done, bus.busy}, 2'b00);
    chk({tag, ".hold"}, {bus.cout, bus.sum}, e);
  endtask

  initial begin
    int k;
    int nd;
    logic [N:0] got;
    errors = 0;
    checks = 0;
    rst = 1'b1;
    bus.start = 1'b0;
    bus.a = '0;
    bus.b = '0;
    bus.cin = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("reset", {bus.busy, bus.done, bus.cout, bus.sum}, '0);

    run_add("zero", 8'h00, 8'h00, 1'b0);
    run_add("one", 8'h01, 8'h01, 1'b0);
    run_add("msb", 8'h80, 8'h01, 1'b0);
    run_add("ripple", 8'hFF, 8'h01, 1'b0);
    run_add("max", 8'hFF, 8'hFF, 1'b1);

    // Restart attempt during RUN must be ignored.
    @(negedge clk);
    bus.start = 1'b1;
    bus.a = 8'h0F;
    bus.b = 8'h01;
    bus.cin = 1'b0;
    @(negedge clk);
    bus.start = 1'b0;
    nd = 0;
    got = '0;
    for (k = 1; k < 2 * N + 8; k++) begin
      if (k == 3) begin
        bus.start = 1'b1;
        bus.a = 8'hAA;
        bus.b = 8'h33;
      end else begin
        bus.start = 1'b0;
      end
      if (bus.done) begin
        nd++;
        got = {bus.cout, bus.sum};
      end
      @(negedge clk);
    end
    chk("restart.ndone", nd, 1);
    chk("restart.res", got, 9'h010);

    // Reset in the middle of RUN discards the result.
    @(negedge clk);
    bus.start = 1'b1;
    bus.a = 8'h55;
    bus.b = 8'h55;
    bus.cin = 1'b0;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("midrst.state", {bus.busy, bus.done, bus.cout, bus.sum}, '0);
    nd = 0;
    for (k = 0; k < N + 4; k++) begin
      if (bus.done || bus.busy) nd++;
      @(negedge clk);
    end
    chk("midrst.quiet", nd, 0);
    run_add("after_rst", 8'h55, 8'h55, 1'b0);

    for (int i = 0; i < 20; i++) begin
      run_add("rand", N'($urandom), N'($urandom), 1'($urandom));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
